// File: rtl/wb_rr_arbiter_if.sv
// Wishbone bundle between NUM_MASTERS masters, the shared slave and the round-robin arbiter.
// The arbiter uses the slave modport; the environment driving masters and slave uses the master modport.
interface wb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
);
  logic [NUM_MASTERS-1:0]        m_cyc_i;
  logic [NUM_MASTERS-1:0]        m_stb_i;
  logic [NUM_MASTERS-1:0]        m_we_i;
  logic [NUM_MASTERS*ADDR_W-1:0] m_adr_i;
  logic [NUM_MASTERS*DATA_W-1:0] m_dat_i;
  logic [NUM_MASTERS-1:0]        m_ack_o;
  logic [NUM_MASTERS-1:0]        m_err_o;
  logic [DATA_W-1:0]             m_dat_o;
  logic                          s_cyc_o;
  logic                          s_stb_o;
  logic                          s_we_o;
  logic [ADDR_W-1:0]             s_adr_o;
  logic [DATA_W-1:0]             s_dat_o;
  logic [DATA_W-1:0]             s_dat_i;
  logic                          s_ack_i;
  logic [NUM_MASTERS-1:0]        gnt_o;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
    output m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, gnt_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
    input  m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, gnt_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone classic arbiter: grant held for a whole cyc, one idle cycle between owners.
// Optional stuck-slave watchdog enabled by defining WB_ARB_TIMEOUT_EN (TIMEOUT_CYC cycles).
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input logic              clk,
  input logic              rst,
  wb_rr_arbiter_if.slave   bus
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;

  logic                   busy;
  logic [NUM_MASTERS-1:0] req;
  logic                   pick_vld;
  logic [IDX_W-1:0]       pick_idx;
  int                     cand;

  logic                   cyc_g, stb_g, we_g;
  logic [ADDR_W-1:0]      adr_g;
  logic [DATA_W-1:0]      dat_g;
  logic                   wd_expire;

  assign busy = (state_q == BUSY);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0]        wd_cnt_q, wd_cnt_d;
  logic [NUM_MASTERS-1:0] err_q, err_d;
  logic [NUM_MASTERS-1:0] lock_q, lock_d;

  // A master cut off by the watchdog stays locked out until it drops cyc.
  assign req = bus.m_cyc_i & ~lock_q;

  always_comb begin
    wd_cnt_d  = '0;
    err_d     = '0;
    wd_expire = busy && bus.s_stb_o && !bus.s_ack_i &&
                (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1));
    if (busy && bus.s_stb_o && !bus.s_ack_i && !wd_expire) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end
    if (wd_expire) begin
      err_d = gnt_q;
    end
    lock_d = (lock_q & bus.m_cyc_i) | err_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
      err_q    <= '0;
      lock_q   <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
      lock_q   <= lock_d;
    end
  end

  assign bus.m_err_o = err_q;
`else
  assign req         = bus.m_cyc_i;
  assign wd_expire   = 1'b0;
  assign bus.m_err_o = '0;
`endif

  // First requester at or after rr_ptr, wrapping past the top index.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = (int'(rr_ptr_q) + k) % NUM_MASTERS;
      if (!pick_vld && req[IDX_W'(cand)]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(cand);
      end
    end
  end

  // One-hot AND-OR mux of the granted master's request signals.
  always_comb begin
    cyc_g = 1'b0;
    stb_g = 1'b0;
    we_g  = 1'b0;
    adr_g = '0;
    dat_g = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_q[i]) begin
        cyc_g = bus.m_cyc_i[i];
        stb_g = bus.m_stb_i[i];
        we_g  = bus.m_we_i[i];
        adr_g = bus.m_adr_i[i*ADDR_W +: ADDR_W];
        dat_g = bus.m_dat_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d         = BUSY;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          rr_ptr_d        = IDX_W'((int'(pick_idx) + 1) % NUM_MASTERS);
        end
      end
      BUSY: begin
        if (!cyc_g || wd_expire) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.s_cyc_o = busy & cyc_g;
  assign bus.s_stb_o = busy & stb_g;
  assign bus.s_we_o  = busy & we_g;
  assign bus.s_adr_o = busy ? adr_g : '0;
  assign bus.s_dat_o = busy ? dat_g : '0;
  assign bus.m_ack_o = gnt_q & {NUM_MASTERS{bus.s_ack_i & busy}};
  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.gnt_o   = gnt_q;

endmodule
